// File: rtl/rf_wb_arbiter.sv
// Register-file write front end: merges ALU (A) and load (B) writebacks into one
// registered write port, tracks pending writes per register, and bypasses reads.
module rf_wb_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_W      = 2,
   parameter int STARVE     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   input  logic [ADDR_WIDTH-1:0] alloc_addr,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] q1_addr,
   input  logic [ADDR_WIDTH-1:0] q2_addr,
   input  logic [DATA_WIDTH-1:0] rf_rdata1,
   input  logic [DATA_WIDTH-1:0] rf_rdata2,
   output logic [DATA_WIDTH-1:0] q1_data,
   output logic [DATA_WIDTH-1:0] q2_data,
   output logic                  q1_busy,
   output logic                  q2_busy,
   output logic                  err_unalloc
);
   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam int BW = $clog2(STARVE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [BW-1:0] B_MAX = BW'(STARVE);

   logic [BW-1:0]    b_wait;
   logic             b_turn;
   logic             grant_a;
   logic             grant_b;
   logic             dec_any;
   logic             alloc_inc;
   logic             hit1;
   logic             hit2;
   logic [CNT_W-1:0] cnt_q [1:NREG-1];
   logic [CNT_W-1:0] cnt_v [NREG];

   // x0 never holds a reservation, so its count is tied to zero
   always_comb begin
      cnt_v[0] = '0;
      for (int r = 1; r < NREG; r++) cnt_v[r] = cnt_q[r];
   end

   assign b_turn  = (b_wait == B_MAX);
   assign a_ready = !(b_turn && b_valid);
   assign b_ready = !a_valid || b_turn;
   assign grant_a = a_valid && a_ready;
   assign grant_b = b_valid && b_ready && !grant_a;

   assign dec_any     = rf_wen && (cnt_v[rf_waddr] != '0);
   assign alloc_ready = (alloc_addr == '0) || (cnt_v[alloc_addr] != CNT_MAX) ||
                        (dec_any && (rf_waddr == alloc_addr));
   assign alloc_inc   = alloc_valid && alloc_ready && (alloc_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_wait   <= '0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         if (grant_b || !b_valid) b_wait <= '0;
         else if (!b_ready && !b_turn) b_wait <= b_wait + BW'(1);

         if (grant_a) begin
            rf_wen   <= (a_addr != '0);
            rf_waddr <= a_addr;
            rf_wdata <= a_data;
         end else if (grant_b) begin
            rf_wen   <= (b_addr != '0);
            rf_waddr <= b_addr;
            rf_wdata <= b_data;
         end else begin
            rf_wen   <= 1'b0;
         end
      end
   end

   // a reserve and a retire hitting the same register in one cycle cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
         err_unalloc <= 1'b0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (alloc_inc && (alloc_addr == ADDR_WIDTH'(r)) &&
                !(dec_any && (rf_waddr == ADDR_WIDTH'(r))))
               cnt_q[r] <= cnt_q[r] + CNT_ONE;
            else if (dec_any && (rf_waddr == ADDR_WIDTH'(r)) &&
                     !(alloc_inc && (alloc_addr == ADDR_WIDTH'(r))))
               cnt_q[r] <= cnt_q[r] - CNT_ONE;
         end
         if (rf_wen && (cnt_v[rf_waddr] == '0)) err_unalloc <= 1'b1;
      end
   end

   assign hit1 = rf_wen && (rf_waddr == q1_addr) && (q1_addr != '0);
   assign hit2 = rf_wen && (rf_waddr == q2_addr) && (q2_addr != '0);

   assign q1_data = (q1_addr == '0) ? '0 : (hit1 ? rf_wdata : rf_rdata1);
   assign q2_data = (q2_addr == '0) ? '0 : (hit2 ? rf_wdata : rf_rdata2);

   // the write in flight already counts as retired for busy purposes
   assign q1_busy = (cnt_v[q1_addr] != '0) && !(hit1 && (cnt_v[q1_addr] == CNT_ONE));
   assign q2_busy = (cnt_v[q2_addr] != '0) && !(hit2 && (cnt_v[q2_addr] == CNT_ONE));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, scoreboard, bypass and reset.
module tb_rf_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [4:0]  a_addr, b_addr, alloc_addr, rf_waddr, q1_addr, q2_addr;
   logic [31:0] a_data, b_data, rf_wdata, rf_rdata1, rf_rdata2, q1_data, q2_data;
   logic        alloc_valid, alloc_ready, rf_wen, q1_busy, q2_busy, err_unalloc;

   int vectors = 0;
   int miscompares = 0;

   rf_wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .q1_addr(q1_addr), .q2_addr(q2_addr),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .q1_data(q1_data), .q2_data(q2_data),
      .q1_busy(q1_busy), .q2_busy(q2_busy), .err_unalloc(err_unalloc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 0; a_addr = 0; a_data = 0;
      b_valid = 0; b_addr = 0; b_data = 0;
      alloc_valid = 0; alloc_addr = 0;
      q1_addr = 0; q2_addr = 0;
      rf_rdata1 = 32'hAAAA_0001; rf_rdata2 = 32'hBBBB_0002;
      #12;
      chk("rst_wen", 32'(rf_wen), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_err", 32'(err_unalloc), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd1);
      chk("rst_b_ready", 32'(b_ready), 32'd1);
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_q1_busy", 32'(q1_busy), 32'd0);
      #5 rst_n = 1'b1;
      tick();

      // alloc x5, then A writes x5
      alloc_valid = 1; alloc_addr = 5;
      tick();
      alloc_valid = 0; q1_addr = 5;
      #1 chk("x5_busy_alloc", 32'(q1_busy), 32'd1);
      a_valid = 1; a_addr = 5; a_data = 32'h1234_5678;
      #1 chk("x5_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 0;
      #1;
      chk("x5_wen", 32'(rf_wen), 32'd1);
      chk("x5_waddr", 32'(rf_waddr), 32'd5);
      chk("x5_wdata", rf_wdata, 32'h1234_5678);
      chk("x5_bypass", q1_data, 32'h1234_5678);
      chk("x5_busy_inflight", 32'(q1_busy), 32'd0);
      tick();
      chk("x5_wen_off", 32'(rf_wen), 32'd0);
      chk("x5_busy_after", 32'(q1_busy), 32'd0);
      chk("x5_file_data", q1_data, 32'hAAAA_0001);
      chk("x5_err", 32'(err_unalloc), 32'd0);

      // A writes x0
      a_valid = 1; a_addr = 0; a_data = 32'hFFFF_FFFF;
      #1 chk("x0_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 0; q1_addr = 0;
      #1;
      chk("x0_wen", 32'(rf_wen), 32'd0);
      chk("x0_wdata_loaded", rf_wdata, 32'hFFFF_FFFF);
      chk("x0_q1_data", q1_data, 32'd0);
      chk("x0_q1_busy", 32'(q1_busy), 32'd0);
      chk("x0_alloc_ready", 32'(alloc_ready), 32'd1);

      // fill x7 to three reservations
      alloc_addr = 7; q2_addr = 7;
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1;
         #1 chk($sformatf("x7_alloc_ready_%0d", i), 32'(alloc_ready), 32'd1);
         tick();
      end
      #1;
      chk("x7_full", 32'(alloc_ready), 32'd0);
      chk("x7_busy", 32'(q2_busy), 32'd1);
      a_valid = 1; a_addr = 7; a_data = 32'h7777_0001;
      #1 chk("x7_full_pre_retire", 32'(alloc_ready), 32'd0);
      tick();
      a_valid = 0;
      #1;
      chk("x7_retire_wen", 32'(rf_wen), 32'd1);
      chk("x7_retire_frees", 32'(alloc_ready), 32'd1);
      chk("x7_busy_inflight", 32'(q2_busy), 32'd1);
      tick();
      alloc_valid = 0;
      #1 chk("x7_still_full", 32'(alloc_ready), 32'd0);
      a_valid = 1;
      for (int i = 0; i < 3; i++) tick();
      a_valid = 0;
      tick();
      chk("x7_drained_busy", 32'(q2_busy), 32'd0);
      chk("x7_drained_ready", 32'(alloc_ready), 32'd1);
      chk("x7_err", 32'(err_unalloc), 32'd0);

      // B writes x9 without reservation
      b_valid = 1; b_addr = 9; b_data = 32'h9999_0009;
      #1 chk("x9_b_ready", 32'(b_ready), 32'd1);
      tick();
      b_valid = 0;
      #1;
      chk("x9_wen", 32'(rf_wen), 32'd1);
      chk("x9_waddr", 32'(rf_waddr), 32'd9);
      chk("x9_err_not_yet", 32'(err_unalloc), 32'd0);
      tick();
      chk("x9_err_set", 32'(err_unalloc), 32'd1);

      // A and B both valid: expect A,A,A,B repeating
      a_valid = 1; b_valid = 1; a_addr = 10; b_addr = 11;
      for (int i = 0; i < 8; i++) begin
         a_data = 32'hA000_0000 + 32'(i);
         b_data = 32'hB000_0000 + 32'(i);
         #1;
         chk($sformatf("arb_a_ready_%0d", i), 32'(a_ready), (i % 4 == 3) ? 32'd0 : 32'd1);
         chk($sformatf("arb_b_ready_%0d", i), 32'(b_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
         tick();
         chk($sformatf("arb_waddr_%0d", i), 32'(rf_waddr), (i % 4 == 3) ? 32'd11 : 32'd10);
         chk($sformatf("arb_wdata_%0d", i), rf_wdata,
             (i % 4 == 3) ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i));
         chk($sformatf("arb_wen_%0d", i), 32'(rf_wen), 32'd1);
      end
      a_valid = 0; b_valid = 0;
      tick();
      chk("err_sticky", 32'(err_unalloc), 32'd1);

      // reset while a write is in flight and x3 holds two reservations
      alloc_valid = 1; alloc_addr = 3;
      tick();
      a_valid = 1; a_addr = 12; a_data = 32'hCCCC_000C;
      tick();
      alloc_valid = 0; a_valid = 0; q1_addr = 3; q2_addr = 3;
      #1;
      chk("pre_rst_wen", 32'(rf_wen), 32'd1);
      chk("pre_rst_x3_busy", 32'(q1_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_wen", 32'(rf_wen), 32'd0);
      chk("mid_rst_err", 32'(err_unalloc), 32'd0);
      chk("mid_rst_x3_busy", 32'(q1_busy), 32'd0);
      a_valid = 1; b_valid = 1;
      #1;
      chk("mid_rst_a_ready", 32'(a_ready), 32'd1);
      chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
      a_valid = 0; b_valid = 0;
      #3 rst_n = 1'b1;
      tick();
      chk("post_rst_x3_busy1", 32'(q1_busy), 32'd0);
      chk("post_rst_x3_busy2", 32'(q2_busy), 32'd0);
      chk("post_rst_wen", 32'(rf_wen), 32'd0);
      chk("post_rst_alloc_ready", 32'(alloc_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writer-side front end for the 32×32 register file. It merges two writeback streams (ALU port A, load port B) into the file's single write port through a registered output stage. It keeps a per-register pending-write scoreboard fed by the issue stage. It returns bypassed read data and busy flags for the two read ports.

## Interface
Parameters:
- DATA_WIDTH, 32, data width
- ADDR_WIDTH, 5, register index width
- CNT_W, 2, pending counter width per register (max 3 outstanding)
- STARVE, 3, cycles B may be refused before it gets priority

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid / a_ready  in / out  1 / 1  ALU writeback handshake
- a_addr, a_data  in  5, 32  ALU destination and value
- b_valid / b_ready  in / out  1 / 1  load writeback handshake
- b_addr, b_data  in  5, 32  load destination and value
- alloc_valid / alloc_ready  in / out  1 / 1  issue-stage destination reservation
- alloc_addr  in  5  register being reserved
- rf_wen, rf_waddr, rf_wdata  out  1, 5, 32  register file write port (registered)
- q1_addr, q2_addr  in  5  read-port indices (same as file raddr1/raddr2)
- rf_rdata1, rf_rdata2  in  32  file read data
- q1_data, q2_data  out  32  bypassed read data
- q1_busy, q2_busy  out  1  register still awaiting a write
- err_unalloc  out  1  sticky: a write retired to a register with zero pending count

## Operation
- Arbitration:
  - A has priority unless b_turn = (b_wait == STARVE).
  - a_ready = !(b_turn && b_valid).
  - b_ready = !a_valid || b_turn.
  - At most one grant per cycle.
  - Readies never depend on rf; the output stage always drains.
- b_wait:
  - +1 (saturating at STARVE) on each cycle with b_valid && !b_ready.
  - Cleared to 0 on a B grant or when b_valid = 0.
- Output stage: a granted write loads rf_waddr/rf_wdata.
  - rf_wen = 1 next cycle iff granted addr != 0.
  - A grant to x0 completes the handshake but produces rf_wen = 0.
  - With no grant, rf_wen = 0; rf_waddr/rf_wdata hold.
- Scoreboard: cnt[r] per register, r = 1..31; cnt[0] is constant 0.
  - inc = alloc_valid && alloc_ready && alloc_addr != 0.
  - dec(r) = rf_wen && rf_waddr == r && cnt[r] != 0.
  - inc and dec on the same register in the same cycle: cnt unchanged.
  - alloc_ready = (alloc_addr == 0) || cnt[alloc_addr] != 3, or the same-cycle dec on that register frees a slot.
- Unallocated write: rf_wen to r with cnt[r] == 0 still writes the file and sets err_unalloc; cnt stays 0.
- Read side (combinational), for qN:
  - hit = rf_wen && rf_waddr == qN_addr && qN_addr != 0.
  - qN_data = hit ? rf_wdata : rf_rdata N.
  - qN_busy = (cnt[qN_addr] − (hit && cnt != 0)) != 0.
  - x0 reads: data 0, busy 0.

## Timing
- Reset, asynchronous on rst_n low: rf_wen = 0, rf_waddr = 0, rf_wdata = 0, all cnt = 0, b_wait = 0, err_unalloc = 0.
- Combinational outputs after reset:
  - a_ready = 1.
  - b_ready = !a_valid.
  - alloc_ready = 1.
  - q*_busy = 0.
- Latency: grant at edge N gives rf_wen high during cycle N+1; the file updates at edge N+2 (clock edge ending cycle N+1) and reads the new value from cycle N+2.
- During cycle N+1, bypass supplies the value and busy already excludes this write.
- Throughput: one write per cycle, sustained.
- Reset asserted mid-operation: in-flight output-stage write is dropped (rf_wen forced 0) and all reservations are lost.
- Ready signals are purely combinational from valids and state; no combinational path from rf_rdata to any ready.

## Test plan
- Reset then alloc x5, A writes x5 = 0x1234_5678 → rf_wen=1, waddr=5 one cycle after grant; q1_addr=5 shows data 0x12345678 and busy=0 in that cycle; cnt[5]=0 after.
- A and B both valid every cycle with distinct addrs → A granted 3 cycles, B granted on the 4th (b_turn), then pattern repeats; no cycle has two grants.
- Alloc x7 three times → alloc_ready=0 on a 4th attempt; same cycle as an x7 retire → 4th alloc accepted, cnt stays 3.
- A writes x0 = 0xFFFF_FFFF → a_ready handshake completes, rf_wen stays 0, q1_addr=0 gives data 0, busy 0.
- B writes x9 with no prior alloc → rf_wen=1 to x9, err_unalloc=1 and sticky until reset.
- rst_n low while rf_wen=1 and cnt[3]=2 → rf_wen=0 immediately, q*_busy=0 for x3 after release.
